router_input_vc: RTL and testbench

// - Router input port fed directly by the NIC network side (net_so/net_ro/net_do -> in_si/in_ri/in_di).
// - Holds one packet per virtual channel (even VC0, odd VC1); the polarity bit selects which VC faces the link and which faces the crossbar.
// - Decodes the hop count of the stored packet, requests the ring output or local-PE output, and decrements hop on ring forwarding.

---
 rtl/router_input_vc.sv | 86 ++++++++
 tb/tb_router_input_vc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/router_input_vc.sv
// Router input port with two single-packet virtual channels.
// The polarity bit assigns one VC to the link side and the other to the crossbar side.
module router_input_vc #(
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic             in_si,
  output logic             in_ri,
  input  logic [DW-1:0]    in_di,
  output logic [1:0]       fwd_req,
  output logic             fwd_dir,
  output logic [DW-1:0]    fwd_data,
  input  logic             fwd_gnt,
  output logic             vc_err,
  output logic [CNT_W-1:0] rx_count
);

  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_LO  = 48;
  localparam int HOP_HI  = 55;

  logic [DW-1:0]    r_buf [0:1];
  logic [1:0]       r_full;
  logic             r_vc_err;
  logic [CNT_W-1:0] r_rx_count;

  logic             w_xvc;
  logic [DW-1:0]    w_xbuf;
  logic             w_xfull;
  logic [7:0]       w_hop;
  logic             w_accept;
  logic             w_release;

  assign w_xvc   = ~polarity;
  assign w_xbuf  = r_buf[w_xvc];
  assign w_xfull = r_full[w_xvc];
  assign w_hop   = w_xbuf[HOP_HI:HOP_LO];

  assign in_ri     = ~reset & ~r_full[polarity];
  assign w_accept  = in_si & in_ri;
  // A grant can only matter when something is requested, i.e. the crossbar-side VC is full.
  assign w_release = fwd_gnt & w_xfull;

  assign vc_err   = r_vc_err;
  assign rx_count = r_rx_count;

  always_comb begin
    fwd_req  = '0;
    fwd_dir  = 1'b0;
    fwd_data = '0;
    if (w_xfull) begin
      fwd_dir  = w_xbuf[DIR_BIT];
      fwd_data = w_xbuf;
      if (w_hop == 8'd0) begin
        fwd_req = 2'b10;
      end else begin
        fwd_req                = 2'b01;
        fwd_data[HOP_HI:HOP_LO] = w_hop - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_full     <= '0;
      r_vc_err   <= 1'b0;
      r_rx_count <= '0;
    end else begin
      // Link side and crossbar side always address different VCs, so both updates may land together.
      if (w_accept) begin
        r_buf[polarity]  <= in_di;
        r_full[polarity] <= 1'b1;
        r_rx_count       <= r_rx_count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (in_di[VC_BIT] != polarity) r_vc_err <= 1'b1;
      end
      if (w_release) r_full[w_xvc] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_input_vc.sv
// Self-checking bench for router_input_vc: directed scenarios then randomized traffic,
// compared each cycle against a two-slot packet model; a CNT_W=2 copy checks counter wrap.
module tb_router_input_vc;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        in_si;
  logic        in_ri;
  logic [63:0] in_di;
  logic [1:0]  fwd_req;
  logic        fwd_dir;
  logic [63:0] fwd_data;
  logic        fwd_gnt;
  logic        vc_err;
  logic [15:0] rx_count;

  logic        in_ri2;
  logic [1:0]  fwd_req2;
  logic        fwd_dir2;
  logic [63:0] fwd_data2;
  logic        vc_err2;
  logic [1:0]  rx_count2;

  int checks = 0;
  int errors = 0;

  // Reference model: two packet slots, indexed by VC number.
  bit          m_full [2];
  logic [63:0] m_data [2];
  int          m_cnt;
  bit          m_err;
  bit          pol;

  always #5 clk = ~clk;

  router_input_vc #(.DW(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .in_si(in_si), .in_ri(in_ri), .in_di(in_di),
    .fwd_req(fwd_req), .fwd_dir(fwd_dir), .fwd_data(fwd_data),
    .fwd_gnt(fwd_gnt), .vc_err(vc_err), .rx_count(rx_count)
  );

  router_input_vc #(.DW(64), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .polarity(polarity),
    .in_si(in_si), .in_ri(in_ri2), .in_di(in_di),
    .fwd_req(fwd_req2), .fwd_dir(fwd_dir2), .fwd_data(fwd_data2),
    .fwd_gnt(fwd_gnt), .vc_err(vc_err2), .rx_count(rx_count2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_data[0] = '0;   m_data[1] = '0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive, check all outputs against the model, clock, advance the model.
  task automatic cyc(input bit rst, input bit si, input logic [63:0] di, input bit gnt);
    bit          fv;
    bit          e_ri;
    logic [1:0]  e_req;
    logic [63:0] e_data;
    logic        e_dir;
    reset = rst; polarity = pol; in_si = si; in_di = di; fwd_gnt = gnt;
    #1;
    fv   = ~pol;
    e_ri = !rst && !m_full[pol];
    if (!m_full[fv]) begin
      e_req = 2'b00; e_data = '0; e_dir = 1'b0;
    end else if (m_data[fv][55:48] == 8'd0) begin
      e_req = 2'b10; e_data = m_data[fv]; e_dir = m_data[fv][62];
    end else begin
      e_req = 2'b01; e_data = m_data[fv] - (64'd1 << 48); e_dir = m_data[fv][62];
    end
    chk("in_ri",     {63'd0, in_ri},     {63'd0, e_ri});
    chk("fwd_req",   {62'd0, fwd_req},   {62'd0, e_req});
    chk("fwd_data",  fwd_data,           e_data);
    chk("fwd_dir",   {63'd0, fwd_dir},   {63'd0, e_dir});
    chk("vc_err",    {63'd0, vc_err},    {63'd0, m_err});
    chk("rx_count",  {48'd0, rx_count},  64'(m_cnt % 65536));
    chk("rx_count2", {62'd0, rx_count2}, 64'(m_cnt % 4));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (si && e_ri) begin
        m_full[pol] = 1'b1;
        m_data[pol] = di;
        m_cnt++;
        if (di[63] != pol) m_err = 1'b1;
      end
      if (gnt && m_full[fv]) m_full[fv] = 1'b0;
    end
    pol = rst ? 1'b0 : ~pol;
    @(negedge clk);
    polarity = pol;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    bit rr, ss, gg;
    model_reset();
    pol = 1'b0;
    reset = 1'b1; polarity = 1'b0; in_si = 1'b0; in_di = '0; fwd_gnt = 1'b0;
    @(posedge clk);
    @(negedge clk);

    cyc(1, 0, '0, 0);
    cyc(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    chk("reset_in_ri", {63'd0, in_ri}, 64'd0);

    // Ring packet accepted at polarity 0, requested next cycle with hop decremented.
    cyc(0, 1, 64'h0003_0000_0000_00AA, 0);
    chk("first_req",   {62'd0, fwd_req}, 64'd1);
    chk("first_data",  fwd_data, 64'h0002_0000_0000_00AA);
    chk("first_count", {48'd0, rx_count}, 64'd1);

    // Hop-0 packet at polarity 1 goes to the local PE unmodified.
    cyc(0, 1, 64'h8000_0000_0000_0055, 0);
    chk("local_req",  {62'd0, fwd_req}, 64'd2);
    chk("local_data", fwd_data, 64'h8000_0000_0000_0055);
    chk("local_err",  {63'd0, vc_err}, 64'd0);

    // Both VCs full: nothing accepted in either phase.
    cyc(0, 1, 64'h0001_0000_0000_0077, 0);
    cyc(0, 1, 64'h8001_0000_0000_0077, 0);
    chk("full_ri",    {63'd0, in_ri}, 64'd0);
    chk("full_count", {48'd0, rx_count}, 64'd2);

    // Grant in the VC0 request phase frees VC0.
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    chk("freed_ri", {63'd0, in_ri}, 64'd1);

    // VC bit mismatch: stored, flagged, still forwarded.
    cyc(0, 1, 64'h8001_0000_0000_0011, 0);
    chk("err_set",  {63'd0, vc_err}, 64'd1);
    chk("err_req",  {62'd0, fwd_req}, 64'd1);
    chk("err_data", fwd_data, 64'h8000_0000_0000_0011);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    chk("err_sticky", {63'd0, vc_err}, 64'd1);

    // Reset with both VCs full.
    cyc(0, 1, 64'h8005_0000_0000_0001, 0);
    cyc(0, 1, 64'h0006_0000_0000_0002, 0);
    cyc(1, 0, '0, 0);
    chk("rst_req",   {62'd0, fwd_req}, 64'd0);
    chk("rst_count", {48'd0, rx_count}, 64'd0);
    chk("rst_err",   {63'd0, vc_err}, 64'd0);

    // Four back-to-back accepts with grants: CNT_W=2 counter wraps to 0.
    cyc(0, 1, 64'h0000_0000_0000_0001, 0);
    cyc(0, 1, 64'h8000_0000_0000_0002, 1);
    cyc(0, 1, 64'h0000_0000_0000_0003, 1);
    cyc(0, 1, 64'h8000_0000_0000_0004, 1);
    chk("wrap_count2", {62'd0, rx_count2}, 64'd0);
    chk("wrap_count",  {48'd0, rx_count}, 64'd4);

    for (int i = 0; i < 3000; i++) begin
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0) d[55:48] = 8'd0;
      else if ($urandom_range(0, 3) == 0) d[55:48] = 8'd1;
      rr = ($urandom_range(0, 63) == 0);
      ss = ($urandom_range(0, 9) < 7);
      gg = ($urandom_range(0, 1) == 1);
      cyc(rr, ss, d, gg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
